// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a single-port data memory.
// Each grant runs a fixed ISSUE/WAIT/ACK sequence and counts completions per requester.
module mem_arbiter #(
  parameter int AW = 6,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_w_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out,
  output logic          busy,
  output logic          owner,
  output logic [CW-1:0] m0_count,
  output logic [CW-1:0] m1_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t state, state_nxt;
  logic   prio;       // last-served requester
  logic   lat_we;
  logic   grant_valid;
  logic   grant;

  always_comb begin
    grant_valid = m0_req | m1_req;
    grant       = 1'b0;
    if (m0_req && m1_req) grant = ~prio;
    else                  grant = m1_req;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Ack, rdata and count are registered on the WAIT->ACK edge so all three are
  // visible together in the ACK cycle; mem_addr/mem_data_in double as the latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= 1'b0;
      prio        <= 1'b1;
      lat_we      <= 1'b0;
      mem_w_en    <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      m0_count    <= '0;
      m1_count    <= '0;
    end else begin
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      mem_w_en <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner       <= grant;
            lat_we      <= grant ? m1_we : m0_we;
            mem_w_en    <= grant ? m1_we : m0_we;
            mem_addr    <= grant ? m1_addr : m0_addr;
            mem_data_in <= grant ? m1_wdata : m0_wdata;
          end
        end
        WAIT: begin
          prio <= owner;
          if (owner) begin
            m1_ack   <= 1'b1;
            m1_count <= m1_count + CW'(1);
            if (!lat_we) m1_rdata <= mem_data_out;
          end else begin
            m0_ack   <= 1'b1;
            m0_count <= m0_count + CW'(1);
            if (!lat_we) m0_rdata <= mem_data_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a synchronous-read 64x32 memory model.
module tb_mem_arbiter;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [5:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_w_en;
  logic [5:0]  mem_addr;
  logic [31:0] mem_data_in, mem_data_out;
  logic        busy, owner;
  logic [CW-1:0] m0_count, m1_count;

  mem_arbiter #(.AW(6), .DW(32), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out),
    .busy(busy), .owner(owner), .m0_count(m0_count), .m1_count(m1_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  always_ff @(posedge clk) begin
    if (mem_w_en) mem[mem_addr] <= mem_data_in;
    mem_data_out <= mem[mem_addr];
  end

  typedef struct {
    logic        who;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] shadow [64];
  logic [31:0] exp_rd [2];
  int          exp_cnt [2];
  int          checks = 0;
  int          errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic r, input logic we,
                       input logic [5:0] a, input logic [31:0] d);
    if (m) begin m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d; end
    else   begin m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d; end
  endtask

  task automatic apply_reset();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    exp_q.delete();
  endtask

  // One isolated transaction with cycle-exact timing checks.
  task automatic single_txn(input logic m, input logic we,
                            input logic [5:0] a, input logic [31:0] d);
    exp_t e;
    int   k;
    logic got;
    e.who = m; e.we = we; e.addr = a; e.data = we ? d : shadow[a];
    if (we) shadow[a] = d;
    exp_q.push_back(e);
    drive(m, 1'b1, we, a, d);
    k = 0; got = 1'b0;
    while (!got && k < 8) begin
      tick();
      k++;
      checks++;
      if (mem_w_en !== (we && k == 1)) begin
        errors++;
        $display("FAIL w_en_timing: cycle %0d got %b expected %b", k, mem_w_en, we && k == 1);
      end
      if (k == 1) begin
        checks++;
        if (mem_addr !== a || owner !== m || busy !== 1'b1 || (we && mem_data_in !== d)) begin
          errors++;
          $display("FAIL issue: addr %0d owner %b busy %b data %h expected addr %0d owner %b busy 1 data %h",
                   mem_addr, owner, busy, mem_data_in, a, m, d);
        end
      end
      if ((m ? m1_ack : m0_ack) === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || k != 3) begin
      errors++;
      $display("FAIL ack_latency: got cycle %0d (seen %b) expected cycle 3", k, got);
    end
    e = exp_q.pop_front();
    if (!e.we) exp_rd[e.who] = e.data;
    exp_cnt[e.who] = (exp_cnt[e.who] + 1) % 16;
    checks++;
    if (m0_rdata !== exp_rd[0] || m1_rdata !== exp_rd[1]) begin
      errors++;
      $display("FAIL rdata: got m0 %h m1 %h expected m0 %h m1 %h", m0_rdata, m1_rdata, exp_rd[0], exp_rd[1]);
    end
    checks++;
    if (m0_count !== 4'(exp_cnt[0]) || m1_count !== 4'(exp_cnt[1])) begin
      errors++;
      $display("FAIL count: got m0 %0d m1 %0d expected m0 %0d m1 %0d", m0_count, m1_count, exp_cnt[0], exp_cnt[1]);
    end
    drive(m, 1'b0, we, a, d);
    tick();
    checks++;
    if (busy !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: got busy %b acks %b%b expected 0 00", busy, m0_ack, m1_ack);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (busy !== 1'b0 || owner !== 1'b0 || mem_w_en !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy %b owner %b w_en %b acks %b%b expected all 0",
               busy, owner, mem_w_en, m0_ack, m1_ack);
    end
    checks++;
    if (mem_addr !== 6'd0 || mem_data_in !== 32'd0 || m0_rdata !== 32'd0 || m1_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: got addr %0d din %h rd0 %h rd1 %h expected 0", mem_addr, mem_data_in, m0_rdata, m1_rdata);
    end
    checks++;
    if (m0_count !== '0 || m1_count !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d %0d expected 0 0", m0_count, m1_count);
    end
  endtask

  task automatic test_write_read();
    single_txn(1'b0, 1'b1, 6'd5, 32'h12345678);
    single_txn(1'b0, 1'b0, 6'd5, 32'h0);
    checks++;
    if (m0_rdata !== 32'h12345678 || m0_count !== 4'd2) begin
      errors++;
      $display("FAIL write_read: got rdata %h count %0d expected 12345678 2", m0_rdata, m0_count);
    end
    for (int unsigned i = 0; i < 8; i++)
      single_txn(1'(i), 1'b1, 6'(8 + i), 32'hA5000000 ^ (i * 32'h01010101));
    single_txn(1'b1, 1'b1, 6'd1, 32'h11110001);
    single_txn(1'b0, 1'b1, 6'd2, 32'h22220002);
  endtask

  task automatic test_simultaneous();
    exp_t e;
    int   a0, a1;
    apply_reset();
    e.who = 1'b0; e.we = 1'b0; e.addr = 6'd1; e.data = shadow[1]; exp_q.push_back(e);
    e.who = 1'b1; e.we = 1'b0; e.addr = 6'd2; e.data = shadow[2]; exp_q.push_back(e);
    drive(1'b0, 1'b1, 1'b0, 6'd1, '0);
    drive(1'b1, 1'b1, 1'b0, 6'd2, '0);
    a0 = -1; a1 = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1 || k == 5) begin
        checks++;
        if (owner !== (k == 5)) begin
          errors++;
          $display("FAIL tie_owner: cycle %0d got %b expected %b", k, owner, k == 5);
        end
      end
      if ((m0_ack === 1'b1 || m1_ack === 1'b1) && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        exp_rd[e.who] = e.data;
        exp_cnt[e.who] = exp_cnt[e.who] + 1;
        checks++;
        if (m1_ack !== e.who || (e.who ? m1_rdata : m0_rdata) !== e.data) begin
          errors++;
          $display("FAIL tie_order: got ack m1=%b rdata %h expected ack m1=%b rdata %h",
                   m1_ack, m1_ack ? m1_rdata : m0_rdata, e.who, e.data);
        end
        if (m1_ack) begin a1 = k; drive(1'b1, 1'b0, 1'b0, 6'd2, '0); end
        else        begin a0 = k; drive(1'b0, 1'b0, 1'b0, 6'd1, '0); end
      end
    end
    checks++;
    if (a0 != 3 || a1 != 7) begin
      errors++;
      $display("FAIL tie_timing: got acks at %0d %0d expected 3 7", a0, a1);
    end
  endtask

  task automatic test_contention();
    exp_t e;
    int   k, acks, i0, i1;
    logic pb, who;
    apply_reset();
    for (int unsigned i = 0; i < 4; i++) begin
      e.who = 1'b0; e.we = 1'b0; e.addr = 6'(8 + i);  e.data = shadow[8 + i];  exp_q.push_back(e);
      e.who = 1'b1; e.we = 1'b0; e.addr = 6'(12 + i); e.data = shadow[12 + i]; exp_q.push_back(e);
    end
    drive(1'b0, 1'b1, 1'b0, 6'd8, '0);
    drive(1'b1, 1'b1, 1'b0, 6'd12, '0);
    k = 0; acks = 0; i0 = 0; i1 = 0; pb = 1'b0;
    while (acks < 8 && k < 40) begin
      tick();
      k++;
      if (busy && !pb) begin
        checks++;
        if (exp_q.size() == 0 || owner !== exp_q[0].who || mem_addr !== exp_q[0].addr) begin
          errors++;
          $display("FAIL contention_issue: cycle %0d got owner %b addr %0d", k, owner, mem_addr);
        end
      end
      pb = busy;
      if ((m0_ack === 1'b1 || m1_ack === 1'b1) && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        who = m1_ack;
        exp_rd[e.who] = e.data;
        exp_cnt[e.who] = exp_cnt[e.who] + 1;
        checks++;
        if (who !== e.who || (m0_ack & m1_ack) || k != 4 * acks + 3 ||
            (who ? m1_rdata : m0_rdata) !== e.data) begin
          errors++;
          $display("FAIL contention_ack: cycle %0d got m%0d rdata %h expected m%0d rdata %h at cycle %0d",
                   k, who, who ? m1_rdata : m0_rdata, e.who, e.data, 4 * acks + 3);
        end
        acks++;
        if (who) begin
          i1++;
          drive(1'b1, i1 < 4, 1'b0, 6'(12 + i1), '0);
        end else begin
          i0++;
          drive(1'b0, i0 < 4, 1'b0, 6'(8 + i0), '0);
        end
      end
    end
    checks++;
    if (acks != 8 || m0_count !== 4'd4 || m1_count !== 4'd4) begin
      errors++;
      $display("FAIL contention_total: got acks %0d counts %0d %0d expected 8 4 4", acks, m0_count, m1_count);
    end
    tick();
  endtask

  task automatic test_write_isolation();
    single_txn(1'b0, 1'b1, 6'd7, 32'h87654321);
    single_txn(1'b0, 1'b0, 6'd7, 32'h0);
    single_txn(1'b1, 1'b1, 6'd63, 32'hfedcba98);
    checks++;
    if (m0_rdata !== 32'h87654321) begin
      errors++;
      $display("FAIL isolation_m0: got %h expected 87654321", m0_rdata);
    end
    single_txn(1'b1, 1'b0, 6'd63, 32'h0);
    checks++;
    if (m1_rdata !== 32'hfedcba98 || m0_rdata !== 32'h87654321) begin
      errors++;
      $display("FAIL isolation_readback: got m1 %h m0 %h expected fedcba98 87654321", m1_rdata, m0_rdata);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_ack;
    apply_reset();
    drive(1'b0, 1'b1, 1'b0, 6'd5, '0);
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait: got busy %b ack %b expected 1 0", busy, m0_ack);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || mem_w_en !== 1'b0 || m0_ack !== 1'b0 || m0_count !== '0) begin
      errors++;
      $display("FAIL reset_mid: got busy %b w_en %b ack %b count %0d expected 0 0 0 0",
               busy, mem_w_en, m0_ack, m0_count);
    end
    drive(1'b0, 1'b0, 1'b0, 6'd5, '0);
    rst = 1'b0;
    saw_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (m0_ack === 1'b1 || busy === 1'b1) saw_ack = 1'b1;
    end
    checks++;
    if (saw_ack !== 1'b0 || m0_count !== '0) begin
      errors++;
      $display("FAIL reset_mid_quiet: got activity %b count %0d expected 0 0", saw_ack, m0_count);
    end
    single_txn(1'b0, 1'b0, 6'd5, 32'h0);
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int unsigned i = 0; i < 17; i++)
      single_txn(1'b1, 1'b0, 6'(8 + (i % 8)), 32'h0);
    checks++;
    if (m1_count !== 4'd1 || m0_count !== 4'd0) begin
      errors++;
      $display("FAIL wrap: got m1 %0d m0 %0d expected 1 0", m1_count, m0_count);
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 64; i++) shadow[i] = '0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    test_reset();
    test_write_read();
    test_simultaneous();
    test_contention();
    test_write_isolation();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester round-robin arbiter sharing the single-port 64 x 32-bit data memory (6-bit word address, one write enable, 32-bit write/read data). Each requester issues one read or write at a time over a req/ack handshake. The arbiter sequences the memory port through a fixed four-cycle transaction, returns read data, and counts completed transactions per requester. It sits between the memory and its users, such as a core data port and a debug/display reader.

## Interface
Parameters:
- AW, 6: memory word-address width.
- DW, 32: data width.
- CW, 16: width of the per-requester completion counters.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- m0_req / m1_req  in  1  request; held high until the matching ack.
- m0_we / m1_we  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  AW  word address.
- m0_wdata / m1_wdata  in  DW  write data.
- m0_ack / m1_ack  out  1  one-cycle completion pulse.
- m0_rdata / m1_rdata  out  DW  read result; valid from the ack cycle, held until that requester's next read completes.
- mem_w_en  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_data_in  out  DW  memory write data.
- mem_data_out  in  DW  memory read data; valid the cycle after mem_addr is stable.
- busy  out  1  high in every state except IDLE.
- owner  out  1  requester currently granted; holds its last value in IDLE.
- m0_count / m1_count  out  CW  completed transactions; wraps to 0 after 2^CW-1.

## Operation
- FSM states: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
- IDLE transitions:
  - No request: stay in IDLE.
  - One request: grant that requester.
  - Both requesting: grant the requester that does NOT hold the priority pointer's last-served value (round-robin).
  - Both requesting after reset: m0 wins.
- Leaving IDLE:
  - Latch the winner's we, addr and wdata into internal registers.
  - Set owner to the winner.
  - Requester inputs are ignored from this point until ACK.
- ISSUE:
  - mem_addr = latched address.
  - mem_data_in = latched data.
  - mem_w_en = latched we, for exactly this cycle.
- WAIT:
  - mem_w_en = 0.
  - mem_addr is held, so mem_data_out settles.
- ACK:
  - Pulse the owner's ack.
  - On a read, capture mem_data_out into the owner's rdata register.
  - On a write, rdata is unchanged.
  - Increment the owner's count.
  - Set the priority pointer to owner.
- All mem_* outputs are registered and hold their last values in IDLE, except mem_w_en, which is 0 everywhere except ISSUE.
- Requester rules:
  - Drop req on the clock edge that ends its ack cycle.
  - A req still high in the IDLE cycle after ack is treated as a new request.
  - Dropping req before ack does not cancel the transaction; it completes and acks.
- The non-owning requester's req is ignored (not queued) until IDLE.

## Timing
- Reset values:
  - State IDLE.
  - mem_w_en, busy, owner, both acks = 0.
  - mem_addr, mem_data_in = 0.
  - Both rdata and both counts = 0.
  - Priority pointer = 1, so m0 wins the first tie.
- Reset mid-transaction:
  - Abandons the transaction at the next edge with no ack.
  - No count increment.
  - mem_w_en is 0 from that edge on.
  - A write whose ISSUE cycle already completed has already been committed.
- Latency, with req first seen high in IDLE cycle t:
  - ISSUE at t+1 (write committed at the end of t+1).
  - WAIT at t+2.
  - ack high and rdata valid at t+3.
  - Back in IDLE at t+4.
- Throughput: one transaction per 4 cycles. Two continuously asserted requesters alternate, each acked every 8 cycles.
- A request arriving during another's transaction waits at most until the IDLE cycle after that ack. Worst-case wait is 4 cycles plus its own 4.

## Test plan
- Single write then read:
  - m0 writes 32'h12345678 to addr 5, then reads addr 5.
  - Required: m0_ack at t+3 of each request; mem_w_en high only at t+1 of the write; m0_rdata = 32'h12345678; m0_count = 2.
- Simultaneous requests after reset:
  - m0 reads addr 1 and m1 reads addr 2 in the same cycle.
  - Required: m0 acked first, m1 acked 4 cycles later; owner sequence 0 then 1.
- Sustained contention:
  - Both hold req with back-to-back reads for 32 cycles.
  - Required: acks strictly alternate m0, m1, m0, ...; each count = 4; no transaction from the non-owner is ever issued.
- Write isolation:
  - m1 writes 32'hfedcba98 to addr 63 while m0 holds m0_rdata = 32'h87654321.
  - Required: m0_rdata unchanged; m1_rdata unchanged; addr 63 reads back 32'hfedcba98.
- Reset mid-operation:
  - Assert rst during WAIT of an m0 read.
  - Required: no m0_ack; m0_count = 0; busy = 0 and mem_w_en = 0 from the next edge; a fresh request completes normally.
- Counter wrap:
  - Use CW = 4 and 17 m1 transactions.
  - Required: m1_count = 1 after the 17th ack.
